// File: rtl/itof_issue_ctrl.sv
// -----------------------------------------------------------------------------
// itof_issue_ctrl
//
// Issue/retire controller for a fixed-latency int-to-float pipeline (itof).
// Requests are forwarded straight to the pipeline. A valid/tag shift register
// tracks each operand through the NSTAGE-clock pipeline. Results are then
// captured into a small result FIFO together with their tag. Requests are
// accepted only while in-flight operands plus queued results leave room in
// the FIFO. Because of this, a result arriving from the pipeline always finds
// a free slot. The pipeline itself is never stalled.
//
// Parameters
//   NSTAGE : latency of the attached itof pipeline in clocks (>= 1)
//   TAGW   : request tag width
//   QDEPTH : result FIFO depth (power of two, >= 2)
//
// Ports
//   clk        in   single clock, rising edge
//   rstn       in   asynchronous active-low reset
//   req_valid  in   conversion request valid
//   req_ready  out  request accept (credit available)
//   req_x      in   32-bit two's-complement operand
//   req_tag    in   destination tag
//   itof_x     out  operand to the itof pipeline (combinational copy of req_x)
//   itof_y     in   IEEE-754 single result from the itof pipeline
//   res_valid  out  result available at FIFO head
//   res_ready  in   consumer accept
//   res_y      out  float result at FIFO head
//   res_tag    out  tag of res_y
// -----------------------------------------------------------------------------
module itof_issue_ctrl #(
    parameter int NSTAGE = 2,
    parameter int TAGW   = 5,
    parameter int QDEPTH = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     req_x,
    input  logic [TAGW-1:0] req_tag,
    output logic [31:0]     itof_x,
    input  logic [31:0]     itof_y,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [31:0]     res_y,
    output logic [TAGW-1:0] res_tag
);

    localparam int AW = $clog2(QDEPTH);              // pointer width
    localparam int CW = $clog2(QDEPTH + 1);          // occupancy 0..QDEPTH
    localparam int SW = $clog2(NSTAGE + QDEPTH + 1); // inflight + occupancy

    // Tracker: stage 1 is index 0, stage NSTAGE is index NSTAGE-1.
    logic [NSTAGE-1:0] trk_vld_q;
    logic [NSTAGE-1:0] trk_vld_d;
    logic [TAGW-1:0]   trk_tag_q [NSTAGE];
    logic [TAGW-1:0]   trk_tag_d [NSTAGE];

    // Result FIFO storage (kept in flops so it can be cleared by reset).
    logic [31:0]       mem_y_q   [QDEPTH];
    logic [TAGW-1:0]   mem_tag_q [QDEPTH];
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q,  count_d;

    logic              accept;
    logic              push;
    logic              pop;
    logic [SW-1:0]     inflight;

    // The operand goes straight to the pipeline; the tracker decides later
    // whether the value coming out of it is a real result.
    assign itof_x = req_x;

    assign accept = req_valid & req_ready;
    assign push   = trk_vld_q[NSTAGE-1];
    assign pop    = res_valid & res_ready;

    // Tracker next state: a plain shift register with no stall. Stage 1
    // records whether this edge accepts, later stages copy their predecessor.
    generate
        for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_trk
            if (gi == 0) begin : g_head
                assign trk_vld_d[gi] = accept;
                assign trk_tag_d[gi] = req_tag;
            end else begin : g_body
                assign trk_vld_d[gi] = trk_vld_q[gi-1];
                assign trk_tag_d[gi] = trk_tag_q[gi-1];
            end
        end
    endgenerate

    // Number of operands currently inside the itof pipeline.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            inflight = inflight + SW'(trk_vld_q[i]);
        end
    end

    // Credit check uses registered state only. A pop in this cycle frees its
    // slot for the next cycle, never combinationally for this one.
    assign req_ready = (inflight + SW'(count_q)) < SW'(QDEPTH);

    // Pointer and occupancy update. Pointers are AW bits wide, so they wrap
    // modulo QDEPTH on their own.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            trk_vld_q <= '0;
            for (int i = 0; i < NSTAGE; i++) begin
                trk_tag_q[i] <= '0;
            end
            for (int i = 0; i < QDEPTH; i++) begin
                mem_y_q[i]   <= '0;
                mem_tag_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            trk_vld_q <= trk_vld_d;
            for (int i = 0; i < NSTAGE; i++) begin
                trk_tag_q[i] <= trk_tag_d[i];
            end
            // The credit rule guarantees a free slot whenever push is set.
            if (push) begin
                mem_y_q[wr_ptr_q]   <= itof_y;
                mem_tag_q[wr_ptr_q] <= trk_tag_q[NSTAGE-1];
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Outputs come from registers only. There is no path from itof_y to res_y.
    assign res_valid = (count_q != '0);
    assign res_y     = mem_y_q[rd_ptr_q];
    assign res_tag   = mem_tag_q[rd_ptr_q];

endmodule

// File: tb/tb_itof_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_itof_issue_ctrl
//
// Bench for itof_issue_ctrl. The attached itof unit is modelled as an
// NSTAGE-deep register pipeline around a reference int-to-float conversion.
// A scoreboard queue holds the accepted requests and their expected results.
// The result head is compared against this queue in every cycle where
// res_valid is high.
// -----------------------------------------------------------------------------
module tb_itof_issue_ctrl;

    localparam int NSTAGE = 2;
    localparam int TAGW   = 5;
    localparam int QDEPTH = 4;

    logic            clk = 1'b0;
    logic            rstn = 1'b1;
    logic            req_valid;
    logic            req_ready;
    logic [31:0]     req_x;
    logic [TAGW-1:0] req_tag;
    logic [31:0]     itof_x;
    logic [31:0]     itof_y;
    logic            res_valid;
    logic            res_ready;
    logic [31:0]     res_y;
    logic [TAGW-1:0] res_tag;

    itof_issue_ctrl #(.NSTAGE(NSTAGE), .TAGW(TAGW), .QDEPTH(QDEPTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_tag   (req_tag),
        .itof_x    (itof_x),
        .itof_y    (itof_y),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_y     (res_y),
        .res_tag   (res_tag)
    );

    always #5 clk = ~clk;

    // Reference int-to-float conversion with round-to-nearest-even.
    function automatic logic [31:0] i2f(input logic [31:0] x);
        logic        s;
        logic [31:0] m;
        logic [32:0] keep;
        logic [31:0] rem;
        logic [31:0] half;
        logic [7:0]  e;
        int          p;
        int          sh;
        if (x == 32'd0) return 32'd0;
        s = x[31];
        m = s ? (~x + 32'd1) : x;
        p = 0;
        for (int i = 0; i < 32; i++) if (m[i]) p = i;
        e = 8'(127 + p);
        if (p <= 23) return {s, e, 23'(m << (23 - p))};
        sh   = p - 23;
        keep = 33'(m >> sh);
        rem  = m & ((32'd1 << sh) - 32'd1);
        half = 32'd1 << (sh - 1);
        if (rem > half || (rem == half && keep[0])) keep = keep + 33'd1;
        if (keep[24]) begin
            keep = keep >> 1;
            e    = e + 8'd1;
        end
        return {s, e, keep[22:0]};
    endfunction

    // Attached itof unit: fixed NSTAGE-clock pipeline.
    logic [31:0] pipe [NSTAGE];
    always @(posedge clk) begin
        pipe[0] <= i2f(itof_x);
        for (int i = 1; i < NSTAGE; i++) pipe[i] <= pipe[i-1];
    end
    assign itof_y = pipe[NSTAGE-1];

    typedef struct packed {
        logic [31:0]     y;
        logic [TAGW-1:0] tag;
    } res_t;

    res_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          acc_cnt = 0;
    int          pop_cnt = 0;
    int          cyc = 0;
    int          first_pop = 0;
    int          last_pop = 0;
    int          n;
    int          a0;
    bit          verbose = 1'b1;
    logic [31:0] cur_exp;

    logic [31:0] t2_x [4];
    logic [31:0] t2_y [4];
    logic [31:0] t3_y [5];
    logic [31:0] t4_y [3];
    logic [31:0] specials [6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // One clock: check the head, book accept/pop, advance to just after the edge.
    task automatic tick();
        if (res_valid) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("head_y", res_y, exp_q[0].y);
                check("head_tag", 32'(res_tag), 32'(exp_q[0].tag));
            end
        end
        if (req_valid && req_ready) begin
            exp_q.push_back('{y: cur_exp, tag: req_tag});
            acc_cnt++;
        end
        if (res_valid && res_ready) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            if (pop_cnt == 0) first_pop = cyc;
            last_pop = cyc;
            pop_cnt++;
            if (verbose) $display("pop  cyc=%0d tag=%0d y=%h", cyc, res_tag, res_y);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input string name);
        req_valid = 1'b0;
        res_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        t2_x = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
        t2_y = '{32'hBF80_0000, 32'h0000_0000, 32'hCF00_0000, 32'h4F00_0000};
        t3_y = '{32'h0000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
        t4_y = '{32'h4120_0000, 32'h4130_0000, 32'h4140_0000};
        specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0100_0001};

        req_valid = 1'b0;
        req_x     = '0;
        req_tag   = '0;
        res_ready = 1'b0;
        cur_exp   = '0;

        // Power-on reset: outputs settle while rstn is low.
        #1 rstn = 1'b0;
        #2;
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_y", res_y, 32'd0);
        check("rst_res_tag", 32'(res_tag), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        #3 rstn = 1'b1;

        // Single request. The accept edge is edge 1, and res_valid rises after edge NSTAGE+1.
        res_ready = 1'b1;
        req_valid = 1'b1;
        req_x     = 32'h0000_0001;
        req_tag   = 5'd3;
        cur_exp   = 32'h3F80_0000;
        check("t1_ready", 32'(req_ready), 32'd1);
        a0 = acc_cnt;
        tick();
        req_valid = 1'b0;
        check("t1_accept", 32'(acc_cnt - a0), 32'd1);
        n = 1;
        while (!res_valid && n < 20) begin
            tick();
            n++;
        end
        check("t1_latency", 32'(n), 32'(NSTAGE + 1));
        check("t1_y", res_y, 32'h3F80_0000);
        check("t1_tag", 32'(res_tag), 32'd3);
        tick();
        check("t1_one_wide", 32'(res_valid), 32'd0);

        // Back-to-back stream of boundary operands.
        pop_cnt = 0;
        a0 = acc_cnt;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req_x     = t2_x[i];
            req_tag   = TAGW'(i);
            cur_exp   = t2_y[i];
            tick();
        end
        req_valid = 1'b0;
        check("t2_accepts", 32'(acc_cnt - a0), 32'd4);
        n = 0;
        while (pop_cnt < 4 && n < 20) begin
            tick();
            n++;
        end
        check("t2_pops", 32'(pop_cnt), 32'd4);
        check("t2_consecutive", 32'(last_pop - first_pop), 32'd3);

        // Backpressure: exactly QDEPTH accepts, then credit only after a pop.
        res_ready = 1'b0;
        req_valid = 1'b1;
        pop_cnt   = 0;
        a0 = acc_cnt;
        for (int i = 0; i < 10; i++) begin
            n = (acc_cnt - a0 > 4) ? 4 : acc_cnt - a0;
            req_x   = 32'(n);
            req_tag = TAGW'(n);
            cur_exp = t3_y[n];
            tick();
        end
        check("t3_accepts", 32'(acc_cnt - a0), 32'd4);
        check("t3_ready_low", 32'(req_ready), 32'd0);
        check("t3_res_valid", 32'(res_valid), 32'd1);
        req_x   = 32'd4;
        req_tag = 5'd4;
        cur_exp = t3_y[4];
        res_ready = 1'b1;
        check("t3_no_comb_ready", 32'(req_ready), 32'd0);
        tick();
        res_ready = 1'b0;
        check("t3_ready_after_pop", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        check("t3_accepts_total", 32'(acc_cnt - a0), 32'd5);
        drain("t3_drained");
        check("t3_pops", 32'(pop_cnt), 32'd5);
        check("t3_idle", 32'(res_valid), 32'd0);

        // Push and pop on the same edge while two results are queued.
        res_ready = 1'b0;
        pop_cnt   = 0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1;
            req_x     = 32'(10 + i);
            req_tag   = TAGW'(10 + i);
            cur_exp   = t4_y[i];
            tick();
        end
        req_valid = 1'b0;
        tick();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("t4_head_tag", 32'(res_tag), 32'd11);
        check("t4_ready", 32'(req_ready), 32'd1);
        drain("t4_drained");
        check("t4_pops", 32'(pop_cnt), 32'd3);

        // Continuous streaming: the pointers wrap several times.
        pop_cnt = 0;
        a0 = acc_cnt;
        res_ready = 1'b1;
        n = 0;
        while (acc_cnt - a0 < 20 && n < 40) begin
            req_valid = 1'b1;
            req_x     = 32'((acc_cnt - a0) * 1000 + 7);
            req_tag   = TAGW'(acc_cnt - a0);
            cur_exp   = i2f(req_x);
            tick();
            n++;
        end
        check("t4_stream_cycles", 32'(n), 32'd20);
        drain("t4_stream_drained");
        check("t4_stream_pops", 32'(pop_cnt), 32'd20);

        // Reset with the pipeline and the FIFO both occupied.
        res_ready = 1'b0;
        a0 = acc_cnt;
        n = 0;
        while (acc_cnt - a0 < 4 && n < 10) begin
            req_valid = 1'b1;
            req_x     = 32'(20 + acc_cnt - a0);
            req_tag   = TAGW'(20 + acc_cnt - a0);
            cur_exp   = i2f(req_x);
            tick();
            n++;
        end
        req_valid = 1'b0;
        check("t5_loaded", 32'(acc_cnt - a0), 32'd4);
        #2 rstn = 1'b0;
        #1;
        check("t5_rst_res_valid", 32'(res_valid), 32'd0);
        check("t5_rst_req_ready", 32'(req_ready), 32'd1);
        check("t5_rst_res_y", res_y, 32'd0);
        check("t5_rst_res_tag", 32'(res_tag), 32'd0);
        #1 rstn = 1'b1;
        exp_q.delete();
        res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t5_no_stale", 32'(res_valid), 32'd0);
        end

        // Random soak against the reference conversion.
        verbose = 1'b0;
        pop_cnt = 0;
        a0 = acc_cnt;
        for (int i = 0; i < 4000; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            res_ready = (i % 500 < 100) ? ($urandom_range(0, 7) == 0)
                                        : ($urandom_range(0, 3) != 0);
            req_x     = ($urandom_range(0, 7) == 0) ? specials[$urandom_range(0, 5)]
                                                    : $urandom;
            req_tag   = TAGW'($urandom);
            cur_exp   = i2f(req_x);
            tick();
        end
        drain("soak_drained");
        check("soak_balance", 32'(pop_cnt), 32'(acc_cnt - a0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
